dispatch_sched: RTL and testbench
=================================

# dispatch_sched

Instruction dispatch scheduler between the regfile/rename stage and the back-end structures (ROB, reservation station RS, load/store buffer LSB). It buffers renamed instructions in a small in-order FIFO and issues at most one per cycle. Every issued instruction gets a ROB entry; memory ops also go to the LSB and all other ops go to the RS. Issue stalls while the ROB or the selected target reports full, and the whole queue is discarded on a ROB flush.

## Interface
Parameters:
- DEPTH, 4, FIFO entries, power of two, at least 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- iROB_clr  in  1  flush (mispredict); discard all queued and incoming instructions
- iRF_en  in  1  push request
- iRF_op  in  `OpBus  opcode
- iRF_pc  in  `AddrBus  instruction pc
- iRF_imm  in  `ImmBus  immediate
- iRF_pd  in  1  predicted-taken flag
- iRF_rd_regnm  in  `NameBus  architectural rd
- iRF_rs1_nick / iRF_rs2_nick  in  `NickBus  source tags
- iRF_rs1_dt / iRF_rs2_dt  in  `DataBus  source values
- iROB_nick  in  `NickBus  tag of the next free ROB entry
- iROB_full  in  1  ROB cannot take an instruction next cycle
- iRS_full  in  1  RS cannot take an instruction next cycle
- iLSB_full  in  1  LSB cannot take an instruction next cycle
- oRF_full  out  1  registered; FIFO holds DEPTH entries
- oROB_en  out  1  allocate ROB entry
- oRS_en  out  1  write RS
- oLSB_en  out  1  write LSB
- oDP_op, oDP_pc, oDP_imm, oDP_pd, oDP_rd_regnm, oDP_rd_nick, oDP_rs1_nick, oDP_rs2_nick, oDP_rs1_dt, oDP_rs2_dt  out  payload; widths match the corresponding inputs

## Operation
- FIFO: head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH) and a count register (PTR_W+1 bits, 0..DEPTH).
- Push: iRF_en && !oRF_full && !iROB_clr && rdy. The entry stores all iRF_* fields.
- Operand masking at push:
  - LUI, AUIPC, JAL: rs1/rs2 nick and data stored as 0.
  - I-type and load ops: rs2 nick and data stored as 0.
  - All other ops: both sources stored unmodified.
- Target class: LB/LBU/LH/LHU/LW/SB/SH/SW → LSB. Every other op → RS.
- Issue condition: count != 0 && !iROB_full && !(target full) && !iROB_clr && rdy.
- On issue:
  - Head advances by one.
  - Next cycle: oROB_en=1, exactly one of oRS_en or oLSB_en is 1, and the payload registers hold the head entry with oDP_rd_nick = iROB_nick sampled in the issue cycle.
- No issue: all enables are 0 next cycle; payload registers hold their previous values.
- Stores and branches carry iRF_rd_regnm unmodified; the ROB ignores it for these ops.
- Flush (iROB_clr=1 && rdy): head, tail and count reset to 0, enables are 0 next cycle, and any push in the same cycle is dropped.
- rdy=0: pointers, count and payload hold; enables are forced to 0 next cycle. No instruction issues twice.

## Timing
- Reset values: all enables 0, oRF_full 0, all payload 0, head=tail=count=0.
- Minimum latency from push to issue-visible outputs is 2 cycles: push in cycle N, issue decision in N+1, outputs valid in N+2.
- Issue is in order; a stalled head blocks younger entries even when their target is free.
- Push and issue in the same cycle: count is unchanged.
- Count = DEPTH: push is refused even if an issue happens that cycle. oRF_full deasserts in the following cycle.
- Count = 0: no issue. A push in that cycle is not bypassed to issue.
- Full flags and iROB_nick are sampled combinationally in the issue cycle. Consumers must assert full early enough to cover one in-flight instruction.
- Reset takes priority over flush; flush takes priority over push and issue.

## Structure
- Opcode encodings, `OpBus/`AddrBus/`ImmBus/`NickBus/`DataBus/`NameBus widths and the opcode-class predicates (is_mem, no_rs1, no_rs2) are defined in config.v.
- One sub-module, dispatch_fifo: storage, pointers, count, full and empty. The classifier and the output register stay in dispatch_sched.

## Test plan
- Reset then idle: all outputs 0, oRF_full=0 for 10 cycles.
- Push ADD (rs1 nick 3, rs2 nick 5, rd_regnm 7), iROB_nick=2, no fulls → two cycles later oROB_en=1, oRS_en=1, oLSB_en=0, rd_nick=2, rs nicks 3/5, for exactly one cycle.
- Push LW then ADDI with iLSB_full=1 for 5 cycles → nothing issues until iLSB_full drops. Then LW issues with oLSB_en, followed by ADDI with oRS_en on the next cycle; ADDI carries rs2 nick/data 0.
- Push 4 instructions with iROB_full=1 → oRF_full=1 and a 5th push is ignored. Release iROB_full → all 4 issue in push order and oRF_full clears.
- With 3 queued, assert iROB_clr together with a push → enables 0 next cycle, count 0, and a later single push issues normally.
- With 2 queued, hold rdy=0 for 3 cycles → no enables and state unchanged. Raise rdy → both issue exactly once each.

Source files
------------

// File: rtl/dispatch_sched_pkg.sv
// Shared types for the dispatch scheduler: bus widths, opcode encodings,
// the queued-instruction record and the opcode-class predicates used to
// pick the back-end target and the operand fields that are meaningful.
package dispatch_sched_pkg;

   localparam int OP_W   = 6;
   localparam int ADDR_W = 32;
   localparam int IMM_W  = 32;
   localparam int NICK_W = 4;
   localparam int DATA_W = 32;
   localparam int NAME_W = 5;

   // RV32I opcodes, densely encoded from 1; 0 is an unused/bubble code.
   localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
   localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
   localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
   localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
   localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
   localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
   localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
   localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
   localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
   localparam logic [OP_W-1:0] OP_LB    = 6'd11;
   localparam logic [OP_W-1:0] OP_LH    = 6'd12;
   localparam logic [OP_W-1:0] OP_LW    = 6'd13;
   localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
   localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
   localparam logic [OP_W-1:0] OP_SB    = 6'd16;
   localparam logic [OP_W-1:0] OP_SH    = 6'd17;
   localparam logic [OP_W-1:0] OP_SW    = 6'd18;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
   localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
   localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
   localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
   localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
   localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
   localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
   localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
   localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
   localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
   localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
   localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
   localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
   localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
   localparam logic [OP_W-1:0] OP_OR    = 6'd36;
   localparam logic [OP_W-1:0] OP_AND   = 6'd37;

   // One queued instruction, operands already masked.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] pc;
      logic [IMM_W-1:0]  imm;
      logic              pd;
      logic [NAME_W-1:0] rd_regnm;
      logic [NICK_W-1:0] rs1_nick;
      logic [NICK_W-1:0] rs2_nick;
      logic [DATA_W-1:0] rs1_dt;
      logic [DATA_W-1:0] rs2_dt;
   } dp_entry_t;

   // Loads and stores are the only ops routed to the load/store buffer.
   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                        OP_SB, OP_SH, OP_SW};
   endfunction

   // U-type and JAL have no register sources at all.
   function automatic logic no_rs1(input logic [OP_W-1:0] op);
      return op inside {OP_LUI, OP_AUIPC, OP_JAL};
   endfunction

   // I-type (incl. JALR) and loads read only rs1.
   function automatic logic no_rs2(input logic [OP_W-1:0] op);
      return no_rs1(op) ||
             (op inside {OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                         OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                         OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI});
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Purpose: in-order instruction queue (storage, head/tail, occupancy).
// Latency: a pushed entry is visible at o_dat one cycle after the push.
// Backpressure: o_full is derived from the count register; caller gates push/pop.
// Ports: clk/rst (sync, active-high); i_push/i_pop/i_clr strobes (already
//        qualified by the caller); i_dat entry to enqueue; o_dat head entry;
//        o_full (count == DEPTH), o_empty (count == 0).
module dispatch_fifo
   import dispatch_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_push,
   input  logic      i_pop,
   input  logic      i_clr,
   input  dp_entry_t i_dat,
   output dp_entry_t o_dat,
   output logic      o_full,
   output logic      o_empty
);

   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   dp_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + PTR_W'(1);
         if (i_pop)  r_head <= r_head + PTR_W'(1);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   // Storage needs no reset; only slots below the count are ever read out.
   always_ff @(posedge clk) begin
      if (i_push && !i_clr) r_mem[r_tail] <= i_dat;
   end

   assign o_dat   = r_mem[r_head];
   assign o_full  = (r_count == C_DEPTH);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/dispatch_sched.sv
// Purpose: buffers renamed instructions and issues one per cycle to ROB + RS/LSB.
// Latency: push in N, issue decision in N+1, registered outputs valid in N+2.
// Backpressure: issue stalls on ROB full or selected-target full; oRF_full refuses pushes.
// Ports: clk/rst (sync, active-high); rdy freezes all state; iROB_clr flushes;
//        iRF_* push side from rename; iROB_nick/iROB_full/iRS_full/iLSB_full
//        back-end status; oRF_full to rename; oROB_en/oRS_en/oLSB_en and
//        oDP_* registered issue payload.
module dispatch_sched
   import dispatch_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iROB_clr,
   input  logic              iRF_en,
   input  logic [OP_W-1:0]   iRF_op,
   input  logic [ADDR_W-1:0] iRF_pc,
   input  logic [IMM_W-1:0]  iRF_imm,
   input  logic              iRF_pd,
   input  logic [NAME_W-1:0] iRF_rd_regnm,
   input  logic [NICK_W-1:0] iRF_rs1_nick,
   input  logic [NICK_W-1:0] iRF_rs2_nick,
   input  logic [DATA_W-1:0] iRF_rs1_dt,
   input  logic [DATA_W-1:0] iRF_rs2_dt,
   input  logic [NICK_W-1:0] iROB_nick,
   input  logic              iROB_full,
   input  logic              iRS_full,
   input  logic              iLSB_full,
   output logic              oRF_full,
   output logic              oROB_en,
   output logic              oRS_en,
   output logic              oLSB_en,
   output logic [OP_W-1:0]   oDP_op,
   output logic [ADDR_W-1:0] oDP_pc,
   output logic [IMM_W-1:0]  oDP_imm,
   output logic              oDP_pd,
   output logic [NAME_W-1:0] oDP_rd_regnm,
   output logic [NICK_W-1:0] oDP_rd_nick,
   output logic [NICK_W-1:0] oDP_rs1_nick,
   output logic [NICK_W-1:0] oDP_rs2_nick,
   output logic [DATA_W-1:0] oDP_rs1_dt,
   output logic [DATA_W-1:0] oDP_rs2_dt
);

   dp_entry_t         w_in;
   dp_entry_t         w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_clr;
   logic              w_head_mem;
   logic              w_tgt_full;
   logic              w_issue;

   logic              r_rob_en;
   logic              r_rs_en;
   logic              r_lsb_en;
   dp_entry_t         r_dp;
   logic [NICK_W-1:0] r_rd_nick;

   // Flush wins over push and issue; rdy low freezes everything.
   assign w_clr  = iROB_clr && rdy;
   assign w_push = iRF_en && !w_full && !iROB_clr && rdy;

   // Unused source operands are zeroed on entry so consumers never see
   // stale tags that could spuriously wake on a CDB broadcast.
   always_comb begin
      w_in.op       = iRF_op;
      w_in.pc       = iRF_pc;
      w_in.imm      = iRF_imm;
      w_in.pd       = iRF_pd;
      w_in.rd_regnm = iRF_rd_regnm;
      w_in.rs1_nick = iRF_rs1_nick;
      w_in.rs2_nick = iRF_rs2_nick;
      w_in.rs1_dt   = iRF_rs1_dt;
      w_in.rs2_dt   = iRF_rs2_dt;
      if (no_rs1(iRF_op)) begin
         w_in.rs1_nick = '0;
         w_in.rs1_dt   = '0;
      end
      if (no_rs2(iRF_op)) begin
         w_in.rs2_nick = '0;
         w_in.rs2_dt   = '0;
      end
   end

   dispatch_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_issue),
      .i_clr   (w_clr),
      .i_dat   (w_in),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Only the head is considered, so a blocked head stalls younger entries.
   assign w_head_mem = is_mem(w_head.op);
   assign w_tgt_full = w_head_mem ? iLSB_full : iRS_full;
   assign w_issue    = !w_empty && !iROB_full && !w_tgt_full && !iROB_clr && rdy;

   // Enables pulse for one cycle per issue; payload holds between issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rob_en  <= 1'b0;
         r_rs_en   <= 1'b0;
         r_lsb_en  <= 1'b0;
         r_dp      <= '0;
         r_rd_nick <= '0;
      end else begin
         r_rob_en <= w_issue;
         r_rs_en  <= w_issue && !w_head_mem;
         r_lsb_en <= w_issue && w_head_mem;
         if (w_issue) begin
            r_dp      <= w_head;
            r_rd_nick <= iROB_nick;
         end
      end
   end

   assign oRF_full     = w_full;
   assign oROB_en      = r_rob_en;
   assign oRS_en       = r_rs_en;
   assign oLSB_en      = r_lsb_en;
   assign oDP_op       = r_dp.op;
   assign oDP_pc       = r_dp.pc;
   assign oDP_imm      = r_dp.imm;
   assign oDP_pd       = r_dp.pd;
   assign oDP_rd_regnm = r_dp.rd_regnm;
   assign oDP_rd_nick  = r_rd_nick;
   assign oDP_rs1_nick = r_dp.rs1_nick;
   assign oDP_rs2_nick = r_dp.rs2_nick;
   assign oDP_rs1_dt   = r_dp.rs1_dt;
   assign oDP_rs2_dt   = r_dp.rs2_dt;

endmodule

// File: tb/tb_dispatch_sched.sv
// Bench for dispatch_sched: directed scenarios followed by random traffic,
// checked by a queue-based reference model feeding a scoreboard.
module tb_dispatch_sched;
   import dispatch_sched_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, rdy, iROB_clr, iRF_en, iRF_pd;
   logic [OP_W-1:0]   iRF_op;
   logic [ADDR_W-1:0] iRF_pc;
   logic [IMM_W-1:0]  iRF_imm;
   logic [NAME_W-1:0] iRF_rd_regnm;
   logic [NICK_W-1:0] iRF_rs1_nick, iRF_rs2_nick, iROB_nick;
   logic [DATA_W-1:0] iRF_rs1_dt, iRF_rs2_dt;
   logic              iROB_full, iRS_full, iLSB_full;
   logic              oRF_full, oROB_en, oRS_en, oLSB_en, oDP_pd;
   logic [OP_W-1:0]   oDP_op;
   logic [ADDR_W-1:0] oDP_pc;
   logic [IMM_W-1:0]  oDP_imm;
   logic [NAME_W-1:0] oDP_rd_regnm;
   logic [NICK_W-1:0] oDP_rd_nick, oDP_rs1_nick, oDP_rs2_nick;
   logic [DATA_W-1:0] oDP_rs1_dt, oDP_rs2_dt;

   dispatch_sched #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
      .iRF_en(iRF_en), .iRF_op(iRF_op), .iRF_pc(iRF_pc), .iRF_imm(iRF_imm),
      .iRF_pd(iRF_pd), .iRF_rd_regnm(iRF_rd_regnm),
      .iRF_rs1_nick(iRF_rs1_nick), .iRF_rs2_nick(iRF_rs2_nick),
      .iRF_rs1_dt(iRF_rs1_dt), .iRF_rs2_dt(iRF_rs2_dt),
      .iROB_nick(iROB_nick), .iROB_full(iROB_full), .iRS_full(iRS_full),
      .iLSB_full(iLSB_full), .oRF_full(oRF_full), .oROB_en(oROB_en),
      .oRS_en(oRS_en), .oLSB_en(oLSB_en), .oDP_op(oDP_op), .oDP_pc(oDP_pc),
      .oDP_imm(oDP_imm), .oDP_pd(oDP_pd), .oDP_rd_regnm(oDP_rd_regnm),
      .oDP_rd_nick(oDP_rd_nick), .oDP_rs1_nick(oDP_rs1_nick),
      .oDP_rs2_nick(oDP_rs2_nick), .oDP_rs1_dt(oDP_rs1_dt),
      .oDP_rs2_dt(oDP_rs2_dt)
   );

   typedef struct packed {
      dp_entry_t         e;
      logic [NICK_W-1:0] nick;
   } exp_t;

   dp_entry_t mq[$];      // model of the instruction queue contents
   exp_t      exp_q[$];   // scoreboard: issues awaiting their output cycle
   bit        exp_issue  = 1'b0;
   bit        model_full = 1'b0;
   bit        mon_on     = 1'b0;
   int        checks = 0;
   int        errors = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit tb_mem(input logic [OP_W-1:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   endfunction

   // Builds the queued record from the raw push fields.
   function automatic dp_entry_t tb_mask();
      dp_entry_t e;
      bit u_or_jal, one_src;
      u_or_jal = iRF_op inside {OP_LUI, OP_AUIPC, OP_JAL};
      one_src  = iRF_op inside {OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
      e = '{op: iRF_op, pc: iRF_pc, imm: iRF_imm, pd: iRF_pd,
            rd_regnm: iRF_rd_regnm,
            rs1_nick: u_or_jal ? '0 : iRF_rs1_nick,
            rs2_nick: (u_or_jal || one_src) ? '0 : iRF_rs2_nick,
            rs1_dt:   u_or_jal ? '0 : iRF_rs1_dt,
            rs2_dt:   (u_or_jal || one_src) ? '0 : iRF_rs2_dt};
      return e;
   endfunction

   // Reference model: what should leave the queue at this edge.
   always @(posedge clk) begin
      int  sz;
      bit  iss;
      bit  tgt_full;
      iss = 1'b0;
      if (rst) begin
         mq.delete();
      end else if (rdy && iROB_clr) begin
         mq.delete();
      end else if (rdy) begin
         sz = mq.size();
         if (sz > 0) begin
            tgt_full = tb_mem(mq[0].op) ? iLSB_full : iRS_full;
            if (!iROB_full && !tgt_full) begin
               iss = 1'b1;
               exp_q.push_back('{e: mq[0], nick: iROB_nick});
               void'(mq.pop_front());
            end
         end
         if (iRF_en && sz < DEPTH) mq.push_back(tb_mask());
      end
      exp_issue  = iss;
      model_full = (mq.size() == DEPTH);
      mon_on     = 1'b1;
   end

   // Monitor: compares DUT outputs against the scoreboard every cycle.
   always @(negedge clk) begin
      exp_t x;
      if (mon_on) begin
         chk("rob_en", 256'(oROB_en), 256'(exp_issue));
         chk("rf_full", 256'(oRF_full), 256'(model_full));
         if (oROB_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 256'(1), 256'(0));
            end else begin
               x = exp_q.pop_front();
               chk("rs_en",  256'(oRS_en),  256'(!tb_mem(x.e.op)));
               chk("lsb_en", 256'(oLSB_en), 256'(tb_mem(x.e.op)));
               chk("payload",
                   256'({oDP_op, oDP_pc, oDP_imm, oDP_pd, oDP_rd_regnm, oDP_rd_nick,
                         oDP_rs1_nick, oDP_rs2_nick, oDP_rs1_dt, oDP_rs2_dt}),
                   256'({x.e.op, x.e.pc, x.e.imm, x.e.pd, x.e.rd_regnm, x.nick,
                         x.e.rs1_nick, x.e.rs2_nick, x.e.rs1_dt, x.e.rs2_dt}));
            end
         end else begin
            chk("tgt_en_idle", 256'({oRS_en, oLSB_en}), 256'(0));
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push(input logic [OP_W-1:0] op, input logic [NICK_W-1:0] n1,
                       input logic [NICK_W-1:0] n2, input logic [NAME_W-1:0] rd);
      iRF_en = 1'b1; iRF_op = op; iRF_rs1_nick = n1; iRF_rs2_nick = n2;
      iRF_rd_regnm = rd; iRF_pc = $urandom; iRF_imm = $urandom;
      iRF_pd = 1'($urandom); iRF_rs1_dt = $urandom; iRF_rs2_dt = $urandom;
      @(negedge clk);
      iRF_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; iROB_clr = 1'b0; iRF_en = 1'b0; iRF_op = OP_NOP;
      iRF_pc = '0; iRF_imm = '0; iRF_pd = 1'b0; iRF_rd_regnm = '0;
      iRF_rs1_nick = '0; iRF_rs2_nick = '0; iRF_rs1_dt = '0; iRF_rs2_dt = '0;
      iROB_nick = '0; iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0;
      cyc(3);
      rst = 1'b0;
      // Reset state, then idle.
      chk("rst_payload",
          256'({oDP_op, oDP_pc, oDP_imm, oDP_pd, oDP_rd_regnm, oDP_rd_nick,
                oDP_rs1_nick, oDP_rs2_nick, oDP_rs1_dt, oDP_rs2_dt}), 256'(0));
      chk("rst_enables", 256'({oROB_en, oRS_en, oLSB_en, oRF_full}), 256'(0));
      cyc(10);
      // Single ALU op.
      iROB_nick = 4'd2;
      push(OP_ADD, 4'd3, 4'd5, 5'd7);
      cyc(4);
      // Load blocked by a full LSB holds back a younger ALU op.
      iLSB_full = 1'b1;
      push(OP_LW, 4'd1, 4'd9, 5'd4);
      push(OP_ADDI, 4'd6, 4'd8, 5'd5);
      cyc(3);
      iLSB_full = 1'b0;
      cyc(4);
      // Fill the queue behind a full ROB; 5th push refused.
      iROB_full = 1'b1;
      push(OP_SW, 4'd1, 4'd2, 5'd0);
      push(OP_BEQ, 4'd3, 4'd4, 5'd0);
      push(OP_LUI, 4'd5, 4'd6, 5'd8);
      push(OP_SUB, 4'd7, 4'd8, 5'd9);
      push(OP_XOR, 4'd9, 4'd10, 5'd10);
      cyc(2);
      iROB_full = 1'b0;
      cyc(8);
      // Flush with three queued and a simultaneous push.
      iROB_full = 1'b1;
      push(OP_OR, 4'd1, 4'd1, 5'd1);
      push(OP_LB, 4'd2, 4'd2, 5'd2);
      push(OP_JAL, 4'd3, 4'd3, 5'd3);
      iROB_clr = 1'b1;
      push(OP_AND, 4'd4, 4'd4, 5'd4);
      iROB_clr = 1'b0; iROB_full = 1'b0;
      cyc(3);
      push(OP_SLT, 4'd11, 4'd12, 5'd13);
      cyc(4);
      // Freeze with two queued.
      iROB_full = 1'b1;
      push(OP_JALR, 4'd5, 4'd6, 5'd1);
      push(OP_SH, 4'd7, 4'd8, 5'd0);
      rdy = 1'b0; iROB_full = 1'b0;
      cyc(3);
      rdy = 1'b1;
      cyc(4);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         rdy       = ($urandom_range(0, 9) != 0);
         iROB_clr  = ($urandom_range(0, 39) == 0);
         iROB_full = ($urandom_range(0, 3) == 0);
         iRS_full  = ($urandom_range(0, 3) == 0);
         iLSB_full = ($urandom_range(0, 3) == 0);
         iROB_nick = 4'($urandom);
         iRF_en    = 1'($urandom);
         iRF_op    = 6'($urandom_range(1, 37));
         iRF_pc = $urandom; iRF_imm = $urandom; iRF_pd = 1'($urandom);
         iRF_rd_regnm = 5'($urandom); iRF_rs1_nick = 4'($urandom);
         iRF_rs2_nick = 4'($urandom); iRF_rs1_dt = $urandom; iRF_rs2_dt = $urandom;
         @(negedge clk);
      end
      // Drain.
      rst = 1'b0; rdy = 1'b1; iROB_clr = 1'b0; iRF_en = 1'b0;
      iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0;
      cyc(20);
      chk("drain_full", 256'(oRF_full), 256'(0));
      chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
